btn_conditioner: RTL
====================

# btn_conditioner

Multi-channel, parametrised button conditioner for the PONG front panel: synchronises N raw push-button inputs, debounces each channel independently in both directions (press and release), and produces a stable level plus one-cycle press/release strobes. It also optionally generates hold-to-repeat strobes for continuous paddle movement or menu stepping. It sits between the board button pins and the game/menu control logic, and replaces per-button single-direction debouncers.

## Interface
- N_BTN, 4, number of independent button channels (>=1)
- DEB_CYCLES, 650000, stable cycles required before a level change is accepted (>=2; 6.5 ms at 100 MHz)
- REP_DELAY, 40000000, cycles of continuous hold from press to first repeat strobe (>=2)
- REP_PERIOD, 10000000, cycles between subsequent repeat strobes (>=2)
- Counter widths derived internally via $clog2 of the largest relevant parameter; no width parameters exposed.

- clk  in  1  system clock (100 MHz)
- rst  in  1  synchronous, active-high reset
- btn_in  in  N_BTN  raw asynchronous button inputs, active-high
- btn_level  out  N_BTN  debounced level per channel
- btn_press  out  N_BTN  one-cycle strobe on accepted 0->1 transition
- btn_release  out  N_BTN  one-cycle strobe on accepted 1->0 transition
- btn_repeat  out  N_BTN  one-cycle auto-repeat strobe while held

## Operation
- Per channel: 2-FF synchroniser (sync1, sync2) on btn_in; reset value 0.
- Debounce counter per channel: increments each cycle sync2 != btn_level; cleared any cycle sync2 == btn_level (single-cycle glitch restarts the count).
- When counter == DEB_CYCLES-1 and sync2 != btn_level: btn_level toggles at next edge, counter clears; btn_press (rising) or btn_release (falling) asserted for exactly that one cycle.
- Debounce symmetric: release requires same DEB_CYCLES stability as press.
- Repeat (when compiled in): per-channel repeat counter and phase bit (INITIAL/PERIODIC).
  - On accepted press: counter cleared, phase = INITIAL.
  - While btn_level=1: counter increments; INITIAL at REP_DELAY-1 -> btn_repeat pulse, counter clears, phase = PERIODIC; PERIODIC at REP_PERIOD-1 -> pulse, counter clears.
  - btn_level=0: counter held at 0, phase = INITIAL, no pulses.
  - btn_repeat never coincides with btn_press; first repeat occurs REP_DELAY cycles after btn_press.
- Channels fully independent; simultaneous events on different channels each produce their own strobes in the same cycle.
- All outputs registered; reset values: btn_level=0, btn_press=0, btn_release=0, btn_repeat=0; all counters 0, phase INITIAL.
- rst mid-debounce or mid-hold: everything returns to reset values next edge; held button is re-debounced from zero after rst deasserts (new btn_press generated).

## Timing
- Latency: counting the edge that first samples the new btn_in value into sync1 as edge 1, btn_level and its strobe change after edge DEB_CYCLES+2.
- Strobes are high exactly one cycle, aligned with the cycle btn_level first shows its new value.
- Repeat: btn_repeat at press-cycle + REP_DELAY, then every REP_PERIOD cycles while held.
- Bounce shorter than DEB_CYCLES consecutive stable cycles produces no output activity.

## Configuration
- BTN_CONDITIONER_REPEAT_EN defined: repeat counters, phase bits and btn_repeat logic compiled in as above.
- Not defined: repeat logic absent, btn_repeat tied to all-zeros; port list unchanged; REP_DELAY/REP_PERIOD ignored.

## Test plan
(Bench parameters: N_BTN=2, DEB_CYCLES=8, REP_DELAY=20, REP_PERIOD=5, repeat enabled unless stated.)
- Reset: hold rst with btn_in=2'b11 for 5 cycles -> all outputs 0; after release, btn_level[1:0]=11 after edge 10 with btn_press=11 for one cycle.
- Clean press ch0: btn_in[0] 0->1 held -> btn_level[0] rises after edge 10, btn_press[0] one cycle, ch1 outputs stay 0.
- Bounce: btn_in[0] toggles every 3 cycles for 40 cycles then stays 1 -> no strobes during bounce; single btn_press[0] 10 edges after final stable edge.
- Release: from held 1, btn_in[0]->0 -> btn_level[0] falls after edge 10, btn_release[0] one cycle, btn_repeat stops.
- Repeat: hold ch1 for 40 cycles post-press -> btn_repeat[1] at press+20, +25, +30, +35, +40; no repeat with BTN_CONDITIONER_REPEAT_EN undefined.
- Reset mid-hold: assert rst 1 cycle at press+12 with btn held -> outputs 0, no repeat at press+20; new btn_press 10 edges after rst deasserts.

Source files
------------

// File: rtl/btn_conditioner.sv
// btn_conditioner: N-channel push-button conditioner.
// Each channel is synchronised by two flip-flops and debounced in both
// directions. It produces a stable level and one-cycle press/release strobes.
// Optional hold-to-repeat strobes are compiled in when the macro
// BTN_CONDITIONER_REPEAT_EN is defined. Otherwise btn_repeat is tied low.
module btn_conditioner #(
   parameter int N_BTN      = 4,
   parameter int DEB_CYCLES = 650000,
   parameter int REP_DELAY  = 40000000,
   parameter int REP_PERIOD = 10000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_in,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_repeat
);

   // The debounce counter never exceeds DEB_CYCLES-1.
   localparam int                DEB_W    = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);

   logic [N_BTN-1:0] sync1;
   logic [N_BTN-1:0] sync2;
   logic [DEB_W-1:0] deb_cnt [N_BTN];

   // Two-flop synchroniser for the asynchronous button pins.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= btn_in;
         sync2 <= sync1;
      end
   end

   // Symmetric debounce: any cycle that agrees with the current level restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_level   <= '0;
         btn_press   <= '0;
         btn_release <= '0;
         for (int i = 0; i < N_BTN; i++) deb_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N_BTN; i++) begin
            btn_press[i]   <= 1'b0;
            btn_release[i] <= 1'b0;
            if (sync2[i] == btn_level[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_LAST) begin
               deb_cnt[i]     <= '0;
               btn_level[i]   <= sync2[i];
               btn_press[i]   <= sync2[i];
               btn_release[i] <= ~sync2[i];
            end else begin
               deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
            end
         end
      end
   end

`ifdef BTN_CONDITIONER_REPEAT_EN
   localparam int               REP_MAX    = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
   localparam int               REP_W      = (REP_MAX > 2) ? $clog2(REP_MAX) : 1;
   localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REP_DELAY - 1);
   localparam logic [REP_W-1:0] PER_LAST   = REP_W'(REP_PERIOD - 1);

   typedef enum logic {PH_INITIAL = 1'b0, PH_PERIODIC = 1'b1} phase_t;

   logic [N_BTN-1:0] accept;
   logic [REP_W-1:0] rep_cnt [N_BTN];
   phase_t           phase   [N_BTN];

   // A level change is accepted on the edge where the debounce counter saturates.
   always_comb begin
      accept = '0;
      for (int i = 0; i < N_BTN; i++)
         accept[i] = (sync2[i] != btn_level[i]) && (deb_cnt[i] == DEB_LAST);
   end

   // Hold-to-repeat: an initial delay after a press, then a fixed period while held.
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_repeat <= '0;
         for (int i = 0; i < N_BTN; i++) begin
            rep_cnt[i] <= '0;
            phase[i]   <= PH_INITIAL;
         end
      end else begin
         for (int i = 0; i < N_BTN; i++) begin
            btn_repeat[i] <= 1'b0;
            if (accept[i] || !btn_level[i]) begin
               // Press, release and idle all restart the delay, so a repeat
               // can never share a cycle with a press strobe.
               rep_cnt[i] <= '0;
               phase[i]   <= PH_INITIAL;
            end else if ((phase[i] == PH_INITIAL) && (rep_cnt[i] == DELAY_LAST)) begin
               btn_repeat[i] <= 1'b1;
               rep_cnt[i]    <= '0;
               phase[i]      <= PH_PERIODIC;
            end else if ((phase[i] == PH_PERIODIC) && (rep_cnt[i] == PER_LAST)) begin
               btn_repeat[i] <= 1'b1;
               rep_cnt[i]    <= '0;
            end else begin
               rep_cnt[i] <= rep_cnt[i] + REP_W'(1);
            end
         end
      end
   end
`else
   assign btn_repeat = '0;
`endif

endmodule
